// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter sharing one uart_tx between two byte producers
// Each requester owns a DEPTH-entry circular FIFO; the FSM drains one byte per start/done handshake.
module tx_arbiter #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_data0,
  input  logic         i_valid0,
  output logic         o_ready0,
  input  logic [N-1:0] i_data1,
  input  logic         i_valid1,
  output logic         o_ready1,
  output logic [N-1:0] o_data_tx,
  output logic         o_tx_start,
  input  logic         i_tx_done,
  output logic         o_busy,
  output logic         o_grant
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t        r_state;
  logic [N-1:0]  r_mem0 [DEPTH];
  logic [N-1:0]  r_mem1 [DEPTH];
  logic [AW-1:0] r_wp0, r_rp0, r_wp1, r_rp1;
  logic [AW:0]   r_cnt0, r_cnt1;
  logic [N-1:0]  r_data_tx;
  logic          r_tx_start;
  logic          r_busy;
  logic          r_grant;

  logic w_ready0, w_ready1;
  logic w_push0, w_push1;
  logic w_ne0, w_ne1;
  logic w_idle, w_sel;
  logic w_pop0, w_pop1;

  // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot early.
  assign w_ready0 = (r_cnt0 != L_FULL);
  assign w_ready1 = (r_cnt1 != L_FULL);
  assign w_push0  = i_valid0 && w_ready0;
  assign w_push1  = i_valid1 && w_ready1;
  assign w_ne0    = (r_cnt0 != '0);
  assign w_ne1    = (r_cnt1 != '0);
  assign w_idle   = (r_state == S_IDLE);
  // On a tie the requester that did not hold the last grant wins.
  assign w_sel    = (w_ne0 && w_ne1) ? ~r_grant : w_ne1;
  assign w_pop0   = w_idle && w_ne0 && !w_sel;
  assign w_pop1   = w_idle && w_ne1 && w_sel;

  always_ff @(posedge clk) begin
    if (w_push0) r_mem0[r_wp0] <= i_data0;
    if (w_push1) r_mem1[r_wp1] <= i_data1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp0  <= '0;
      r_rp0  <= '0;
      r_cnt0 <= '0;
      r_wp1  <= '0;
      r_rp1  <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push0) r_wp0 <= r_wp0 + 1'b1;
      if (w_pop0)  r_rp0 <= r_rp0 + 1'b1;
      if (w_push1) r_wp1 <= r_wp1 + 1'b1;
      if (w_pop1)  r_rp1 <= r_rp1 + 1'b1;
      case ({w_push0, w_pop0})
        2'b10:   r_cnt0 <= r_cnt0 + 1'b1;
        2'b01:   r_cnt0 <= r_cnt0 - 1'b1;
        default: r_cnt0 <= r_cnt0;
      endcase
      case ({w_push1, w_pop1})
        2'b10:   r_cnt1 <= r_cnt1 + 1'b1;
        2'b01:   r_cnt1 <= r_cnt1 - 1'b1;
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

  // Grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_data_tx  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_grant    <= 1'b1;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ne0 || w_ne1) begin
            r_state    <= S_START;
            r_grant    <= w_sel;
            r_data_tx  <= w_sel ? r_mem1[r_rp1] : r_mem0[r_rp0];
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_tx_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready0   = w_ready0;
  assign o_ready1   = w_ready1;
  assign o_data_tx  = r_data_tx;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_busy;
  assign o_grant    = r_grant;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - scoreboard bench for tx_arbiter with a timestamped queue reference model
// Stimulus stamps accepted bytes into per-requester queues; a negedge monitor arbitrates and compares.
module tb_tx_arbiter;
  localparam int N = 8;
  localparam int DEPTH = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] i_data0, i_data1;
  logic         i_valid0, i_valid1;
  logic         o_ready0, o_ready1;
  logic [N-1:0] o_data_tx;
  logic         o_tx_start;
  logic         i_tx_done;
  logic         o_busy;
  logic         o_grant;

  tx_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .i_data0(i_data0), .i_valid0(i_valid0), .o_ready0(o_ready0),
    .i_data1(i_data1), .i_valid1(i_valid1), .o_ready1(o_ready1),
    .o_data_tx(o_data_tx), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_grant(o_grant)
  );

  typedef struct {
    logic [7:0] d;
    int         t;
  } ent_t;

  ent_t       q0[$];
  ent_t       q1[$];
  logic [7:0] sent[$];
  logic       sent_g[$];
  logic [7:0] exp_q[$];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   dly = 0;
  int   dcnt = 0;
  bit   g_acc0, g_acc1;

  bit         m_inflight = 0;
  bit         m_grant = 1;
  logic [7:0] m_last = 0;
  int         m_st = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Occupancy of a requester FIFO after edge t: bytes pushed at or before t, not yet popped.
  function automatic int lvl(input int which, input int t);
    int n = 0;
    if (which == 0) begin
      foreach (q0[i]) if (q0[i].t <= t) n++;
    end else begin
      foreach (q1[i]) if (q1[i].t <= t) n++;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    bit       exp_start;
    bit       e0, e1, sel;
    if (reset) begin
      m_inflight = 0;
      m_grant    = 1;
      m_last     = 0;
      chk("rst_start", o_tx_start, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_data", o_data_tx, 0);
      chk("rst_grant", o_grant, 1);
      chk("rst_ready0", o_ready0, 1);
      chk("rst_ready1", o_ready1, 1);
    end else begin
      exp_start = 0;
      if (!m_inflight) begin
        e0 = (q0.size() > 0) && (q0[0].t <= cyc - 1);
        e1 = (q1.size() > 0) && (q1[0].t <= cyc - 1);
        if (e0 || e1) begin
          sel = (e0 && e1) ? !m_grant : e1;
          if (sel) m_last = q1.pop_front().d;
          else     m_last = q0.pop_front().d;
          m_grant    = sel;
          m_inflight = 1;
          m_st       = cyc;
          exp_start  = 1;
        end
      end else if (m_st != cyc - 1 && i_tx_done) begin
        m_inflight = 0;
      end
      if (o_tx_start) begin
        sent.push_back(o_data_tx);
        sent_g.push_back(o_grant);
      end
      chk("tx_start", o_tx_start, exp_start);
      chk("data_tx", o_data_tx, m_last);
      chk("grant", o_grant, m_grant);
      chk("busy", o_busy, m_inflight);
      chk("ready0", o_ready0, lvl(0, cyc) != DEPTH);
      chk("ready1", o_ready1, lvl(1, cyc) != DEPTH);
    end
  end

  // One bench cycle: drive inputs just after the monitor, record accepted pushes in the model.
  task automatic step(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1,
                      input bit spur);
    bit dn;
    @(negedge clk);
    #1;
    dn = 0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) dn = 1;
    end
    if (o_tx_start && dly > 0) dcnt = dly;
    i_tx_done = dn | spur;
    i_valid0  = v0;
    i_data0   = d0;
    i_valid1  = v1;
    i_data1   = d1;
    g_acc0 = v0 && (lvl(0, cyc) != DEPTH);
    g_acc1 = v1 && (lvl(1, cyc) != DEPTH);
    if (g_acc0) q0.push_back('{d0, cyc + 1});
    if (g_acc1) q1.push_back('{d1, cyc + 1});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1;
    i_valid0 = 0;
    i_valid1 = 0;
    i_tx_done = 0;
    dcnt = 0;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_inflight) && k < 3000) begin
      step(0, 8'h00, 0, 8'h00, (dly == 0) && ($urandom_range(3) == 0));
      k++;
    end
    chk("drain_done", (q0.size() == 0 && q1.size() == 0 && !m_inflight), 1);
    idle(3);
  endtask

  task automatic chk_sent(input string nm);
    chk({nm, "_count"}, sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
      chk({nm, "_byte"}, sent[i], exp_q[i]);
  endtask

  initial begin
    reset = 1;
    i_valid0 = 0;
    i_valid1 = 0;
    i_data0 = 0;
    i_data1 = 0;
    i_tx_done = 0;
    repeat (3) @(negedge clk);
    #1;
    reset = 0;

    // single byte
    dly = 3;
    sent.delete();
    sent_g.delete();
    step(1, 8'hA5, 0, 8'h00, 0);
    idle(8);
    exp_q = '{8'hA5};
    chk_sent("single");
    if (sent_g.size() > 0) chk("single_grant", sent_g[0], 0);

    // contention
    do_reset();
    dly = 10;
    sent.delete();
    step(1, 8'h11, 1, 8'h21, 0);
    step(1, 8'h12, 1, 8'h22, 0);
    drain();
    exp_q = '{8'h11, 8'h21, 8'h12, 8'h22};
    chk_sent("contend");

    // FIFO full while WAIT is held
    do_reset();
    dly = 0;
    sent.delete();
    step(1, 8'h40, 0, 8'h00, 0);
    idle(3);
    for (int i = 1; i <= 4; i++) step(0, 8'h00, 1, 8'(8'h30 + i), 0);
    step(0, 8'h00, 1, 8'hFF, 0);
    chk("full_drop", g_acc1, 0);
    idle(1);
    chk("full_ready1", o_ready1, 0);
    dly = 2;
    step(0, 8'h00, 0, 8'h00, 1);
    drain();
    exp_q = '{8'h40, 8'h31, 8'h32, 8'h33, 8'h34};
    chk_sent("full");

    // wrap-around with immediate done
    dly = 1;
    sent.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      int tries = 0;
      exp_q.push_back(8'(i));
      do begin
        step(1, 8'(i), 0, 8'h00, 0);
        tries++;
      end while (!g_acc0 && tries < 50);
    end
    drain();
    chk_sent("wrap");

    // spurious done in IDLE and START
    do_reset();
    dly = 0;
    sent.delete();
    repeat (3) step(0, 8'h00, 0, 8'h00, 1);
    step(1, 8'h55, 0, 8'h00, 0);
    step(0, 8'h00, 0, 8'h00, 1);
    step(0, 8'h00, 0, 8'h00, 1);
    idle(4);
    chk("spur_busy_held", o_busy, 1);
    step(0, 8'h00, 0, 8'h00, 1);
    drain();
    exp_q = '{8'h55};
    chk_sent("spur");

    // reset mid-WAIT
    dly = 0;
    sent.delete();
    for (int i = 1; i <= 4; i++) step(1, 8'(8'h60 + i), 0, 8'h00, 0);
    idle(3);
    do_reset();
    idle(10);
    exp_q = '{8'h61};
    chk_sent("rst_wait");

    // randomized traffic
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      dly = $urandom_range(6, 1);
      for (int k = 0; k < 100; k++)
        step($urandom_range(1) == 1, 8'($urandom), $urandom_range(2) == 0, 8'($urandom),
             $urandom_range(19) == 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
